// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MIPS fetch/decode slice: 6-bit opcode
//   constants, the instruction-type enum handed to EX, and the opcode
//   classifier used by the decode stage.
//   No ports (package).
// ---------------------------------------------------------------------------
package mips_pkg;

    // Opcodes, instruction bits [31:26]
    localparam logic [5:0] ADD   = 6'b000000;
    localparam logic [5:0] SUB   = 6'b000001;
    localparam logic [5:0] AND   = 6'b000010;
    localparam logic [5:0] OR    = 6'b000011;
    localparam logic [5:0] SLT   = 6'b000100;
    localparam logic [5:0] MUL   = 6'b000101;
    localparam logic [5:0] LW    = 6'b001000;
    localparam logic [5:0] SW    = 6'b001001;
    localparam logic [5:0] ADDI  = 6'b001010;
    localparam logic [5:0] SUBI  = 6'b001011;
    localparam logic [5:0] SLTI  = 6'b001100;
    localparam logic [5:0] BNEQZ = 6'b001101;
    localparam logic [5:0] BEQZ  = 6'b001110;
    localparam logic [5:0] HLT   = 6'b111111;

    typedef enum logic [2:0] {
        RR_ALU = 3'd0,
        RM_ALU = 3'd1,
        LOAD   = 3'd2,
        STORE  = 3'd3,
        BRANCH = 3'd4,
        HALT   = 3'd5
    } instr_type_e;

    // Undefined opcodes classify as HALT so a wild fetch stops the core.
    function automatic instr_type_e decode_type(input logic [5:0] op);
        instr_type_e t;
        case (op)
            ADD, SUB, AND, OR, SLT, MUL: t = RR_ALU;
            ADDI, SUBI, SLTI:           t = RM_ALU;
            LW:                         t = LOAD;
            SW:                         t = STORE;
            BEQZ, BNEQZ:                t = BRANCH;
            default:                    t = HALT;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mips_fetch_decode_if.sv
// ---------------------------------------------------------------------------
// mips_fetch_decode_if
//   ID/EX hand-off bundle between the fetch/decode front end and EX.
//   master (front end) drives: id_valid, id_ir, id_npc, id_a, id_b,
//                              id_imm, id_type, halted
//   slave  (EX)        drives: id_ready
// ---------------------------------------------------------------------------
interface mips_fetch_decode_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 10
);
    import mips_pkg::*;

    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_ir;
    logic [ADDR_W-1:0] id_npc;
    logic [XLEN-1:0]   id_a;
    logic [XLEN-1:0]   id_b;
    logic [XLEN-1:0]   id_imm;
    instr_type_e       id_type;
    logic              halted;

    modport master (
        output id_valid, id_ir, id_npc, id_a, id_b, id_imm, id_type, halted,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_ir, id_npc, id_a, id_b, id_imm, id_type, halted,
        output id_ready
    );

endinterface

// File: rtl/mips_regfile.sv
// ---------------------------------------------------------------------------
// mips_regfile
//   NREG x XLEN register file, two combinational read ports, one write
//   port on the rising edge of clk1, synchronous active-high clear.
//   Register 0 always reads 0 and ignores writes.
//   Optional macro MIPS_FD_WB_BYPASS_EN: a read of the register being
//   written in the same cycle returns the incoming write data.
// Ports:
//   clk1, rst               clock, synchronous reset
//   rs_addr/rs_data         read port A
//   rt_addr/rt_data         read port B
//   we, waddr, wdata        write port
// ---------------------------------------------------------------------------
module mips_regfile #(
    parameter  int XLEN   = 32,
    parameter  int NREG   = 32,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_addr,
    output logic [XLEN-1:0]   rs_data,
    input  logic [REG_AW-1:0] rt_addr,
    output logic [XLEN-1:0]   rt_data,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata
);

    logic [XLEN-1:0] regs_q [NREG];

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    // NOTE: this array is cleared on reset because software may read any
    // register before writing it; that forces flops rather than a RAM macro.
    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs_q[waddr] <= wdata;
        end
    end

    // NOTE: each output is assigned first, unconditionally, so no latch forms.
    always_comb begin
        rs_data = regs_q[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end
`ifdef MIPS_FD_WB_BYPASS_EN
        else if (we && waddr == rs_addr) begin
            rs_data = wdata;
        end
`endif
    end

    always_comb begin
        rt_data = regs_q[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end
`ifdef MIPS_FD_WB_BYPASS_EN
        else if (we && waddr == rt_addr) begin
            rt_data = wdata;
        end
`endif
    end

endmodule

// File: rtl/mips_fetch_decode.sv
// ---------------------------------------------------------------------------
// mips_fetch_decode
//   Two-stage MIPS front end: F (PC -> IF/ID latch) and D (IF/ID -> ID/EX
//   latch with register read, sign-extended immediate and type decode).
//   Optional macro MIPS_FD_WB_BYPASS_EN enables write-back forwarding into
//   the register read (see mips_regfile).
// Ports:
//   clk1, rst              clock, synchronous active-high reset
//   imem_addr/imem_rdata   instruction memory (word address, comb. read)
//   br_taken/br_target     redirect from EX/MEM; beats stall
//   wb_en/wb_addr/wb_data  register write-back
//   id_bus (master)        ID/EX latch, valid/ready handshake, halted flag
// ---------------------------------------------------------------------------
module mips_fetch_decode
    import mips_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int ADDR_W = 10,
    parameter  int NREG   = 32,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic              clk1,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_rdata,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    mips_fetch_decode_if.master id_bus
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [XLEN-1:0]   if_ir_q, if_ir_d;
    logic [ADDR_W-1:0] if_npc_q, if_npc_d;
    logic              id_valid_q, id_valid_d;
    logic [XLEN-1:0]   id_ir_q, id_ir_d;
    logic [ADDR_W-1:0] id_npc_q, id_npc_d;
    logic [XLEN-1:0]   id_a_q, id_a_d;
    logic [XLEN-1:0]   id_b_q, id_b_d;
    logic [XLEN-1:0]   id_imm_q, id_imm_d;
    instr_type_e       id_type_q, id_type_d;
    logic              halt_pending_q, halt_pending_d;
    logic              halted_q, halted_d;

    logic              adv;
    logic              redirect;
    logic [XLEN-1:0]   rd_a, rd_b;
    logic [XLEN-1:0]   dec_imm;
    instr_type_e       dec_type;

    assign adv      = !id_valid_q || id_bus.id_ready;
    assign redirect = br_taken && !halted_q;

    // During a redirect the single read port fetches the target word so the
    // IF/ID latch is refilled in the same edge; otherwise it follows the PC.
    assign imem_addr = redirect ? br_target : pc_q;

    assign dec_imm  = {{(XLEN-16){if_ir_q[15]}}, if_ir_q[15:0]};
    assign dec_type = decode_type(if_ir_q[31:26]);

    mips_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk1    (clk1),
        .rst     (rst),
        .rs_addr (REG_AW'(if_ir_q[25:21])),
        .rs_data (rd_a),
        .rt_addr (REG_AW'(if_ir_q[20:16])),
        .rt_data (rd_b),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    always_comb begin
        pc_d           = pc_q;
        if_valid_d     = if_valid_q;
        if_ir_d        = if_ir_q;
        if_npc_d       = if_npc_q;
        id_valid_d     = id_valid_q;
        id_ir_d        = id_ir_q;
        id_npc_d       = id_npc_q;
        id_a_d         = id_a_q;
        id_b_d         = id_b_q;
        id_imm_d       = id_imm_q;
        id_type_d      = id_type_q;
        halt_pending_d = halt_pending_q;
        halted_d       = halted_q;

        // Once halted, everything except the register file is frozen.
        if (!halted_q) begin
            if (redirect) begin
                // Squash both stages' in-flight work, including a pending HLT.
                pc_d           = br_target + 1'b1;
                if_valid_d     = 1'b1;
                if_ir_d        = imem_rdata;
                if_npc_d       = br_target + 1'b1;
                id_valid_d     = 1'b0;
                halt_pending_d = 1'b0;
            end else if (adv) begin
                // A HALT-type instruction has been handed to EX.
                halted_d = id_valid_q && id_bus.id_ready && (id_type_q == HALT);

                // D stage: nothing behind a pending HLT is issued.
                id_valid_d = if_valid_q && !halt_pending_q;
                id_ir_d    = if_ir_q;
                id_npc_d   = if_npc_q;
                id_a_d     = rd_a;
                id_b_d     = rd_b;
                id_imm_d   = dec_imm;
                id_type_d  = dec_type;
                if (if_valid_q && !halt_pending_q && dec_type == HALT) begin
                    halt_pending_d = 1'b1;
                end

                // F stage: stop fetching while a HLT waits in ID/EX.
                if (halt_pending_q) begin
                    if_valid_d = 1'b0;
                end else begin
                    if_valid_d = 1'b1;
                    if_ir_d    = imem_rdata;
                    if_npc_d   = pc_q + 1'b1;
                    pc_d       = pc_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            pc_q           <= '0;
            if_valid_q     <= 1'b0;
            if_ir_q        <= '0;
            if_npc_q       <= '0;
            id_valid_q     <= 1'b0;
            id_ir_q        <= '0;
            id_npc_q       <= '0;
            id_a_q         <= '0;
            id_b_q         <= '0;
            id_imm_q       <= '0;
            id_type_q      <= RR_ALU;
            halt_pending_q <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            if_valid_q     <= if_valid_d;
            if_ir_q        <= if_ir_d;
            if_npc_q       <= if_npc_d;
            id_valid_q     <= id_valid_d;
            id_ir_q        <= id_ir_d;
            id_npc_q       <= id_npc_d;
            id_a_q         <= id_a_d;
            id_b_q         <= id_b_d;
            id_imm_q       <= id_imm_d;
            id_type_q      <= id_type_d;
            halt_pending_q <= halt_pending_d;
            halted_q       <= halted_d;
        end
    end

    assign id_bus.id_valid = id_valid_q;
    assign id_bus.id_ir    = id_ir_q;
    assign id_bus.id_npc   = id_npc_q;
    assign id_bus.id_a     = id_a_q;
    assign id_bus.id_b     = id_b_q;
    assign id_bus.id_imm   = id_imm_q;
    assign id_bus.id_type  = id_type_q;
    assign id_bus.halted   = halted_q;

endmodule

// File: tb/tb_mips_fetch_decode.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_decode
//   Directed bench for mips_fetch_decode: reset, straight-line issue,
//   stall, redirect, write-back bypass, PC wrap, HLT squash, mid-run reset.
// ---------------------------------------------------------------------------
module tb_mips_fetch_decode;

    localparam logic [5:0] T_ADD  = 6'b000000;
    localparam logic [5:0] T_ADDI = 6'b001010;
    localparam logic [5:0] T_HLT  = 6'b111111;

    logic        clk1;
    logic        rst;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [9:0]  br_target;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic [31:0] imem [0:1023];

    int n_checks = 0;
    int n_bad    = 0;

    mips_fetch_decode_if #(.XLEN(32), .ADDR_W(10)) id_bus ();

    mips_fetch_decode dut (
        .clk1       (clk1),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .id_bus     (id_bus)
    );

    assign imem_rdata = imem[imem_addr];

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_hlt;
    logic [4:0]  rs_k, rt_k;

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
        rst = 1'b1; br_taken = 1'b0; br_target = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        id_bus.id_ready = 1'b1;
        w_hlt = {T_HLT, 26'd0};

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_valid",  id_bus.id_valid, 0);
        check("rst_halted", id_bus.halted, 0);
        check("rst_pc",     imem_addr, 0);
        check("rst_ir",     id_bus.id_ir, 0);
        check("rst_npc",    id_bus.id_npc, 0);
        check("rst_a",      id_bus.id_a, 0);
        check("rst_type",   id_bus.id_type, 0);

        // ---------------- straight line ----------------
        w_a = enc_i(T_ADDI, 5'd0, 5'd1, 16'd5);
        w_b = enc_r(T_ADD, 5'd1, 5'd1, 5'd2);
        imem[0] = w_a; imem[1] = w_b; imem[2] = w_hlt;
        imem[3] = enc_i(T_ADDI, 5'd0, 5'd4, 16'd9);
        rst = 1'b0;
        step();                                      // edge 1
        check("sl_e1_valid", id_bus.id_valid, 0);
        check("sl_e1_pc",    imem_addr, 1);
        step();                                      // edge 2
        check("sl_e2_valid", id_bus.id_valid, 1);
        check("sl_e2_ir",    id_bus.id_ir, w_a);
        check("sl_e2_imm",   id_bus.id_imm, 5);
        check("sl_e2_type",  id_bus.id_type, 1);
        check("sl_e2_npc",   id_bus.id_npc, 1);
        step();                                      // edge 3
        check("sl_e3_valid", id_bus.id_valid, 1);
        check("sl_e3_ir",    id_bus.id_ir, w_b);
        check("sl_e3_type",  id_bus.id_type, 0);
        check("sl_e3_npc",   id_bus.id_npc, 2);
        step();                                      // edge 4: HLT in ID/EX
        check("sl_e4_valid",  id_bus.id_valid, 1);
        check("sl_e4_type",   id_bus.id_type, 5);
        check("sl_e4_halted", id_bus.halted, 0);
        check("sl_e4_pc",     imem_addr, 4);
        step();                                      // edge 5: HLT accepted
        check("sl_e5_halted", id_bus.halted, 1);
        check("sl_e5_valid",  id_bus.id_valid, 0);
        check("sl_e5_pc",     imem_addr, 4);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        br_taken = 1'b1; br_target = 10'h020;
        step();
        check("halt_frz_pc",    imem_addr, 4);
        check("halt_frz_valid", id_bus.id_valid, 0);
        check("halt_sticky",    id_bus.halted, 1);
        wb_en = 1'b0; br_taken = 1'b0;
        step();
        check("halt_wb_r5", dut.u_regfile.regs_q[5], 32'h0000_1234);
        check("halt_frz_pc2", imem_addr, 4);

        // ---------------- stall ----------------
        w_a = enc_i(T_ADDI, 5'd0, 5'd1, 16'd7);
        w_b = enc_i(T_ADDI, 5'd0, 5'd2, 16'd9);
        w_c = enc_i(T_ADDI, 5'd3, 5'd3, 16'hFFFF);
        imem[0] = w_a; imem[1] = w_b; imem[2] = w_c; imem[3] = 32'h0;
        id_bus.id_ready = 1'b1;
        do_reset();
        check("rst_clr_halted", id_bus.halted, 0);
        step();
        step();
        check("st_ir0", id_bus.id_ir, w_a);
        id_bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("st_hold_ir%0d", i),  id_bus.id_ir, w_a);
            check($sformatf("st_hold_npc%0d", i), id_bus.id_npc, 1);
            check($sformatf("st_hold_pc%0d", i),  imem_addr, 2);
        end
        id_bus.id_ready = 1'b1;
        step();
        check("st_rel_ir",  id_bus.id_ir, w_b);
        check("st_rel_npc", id_bus.id_npc, 2);
        check("st_rel_pc",  imem_addr, 3);
        step();
        check("st_c_ir",   id_bus.id_ir, w_c);
        check("st_c_imm",  id_bus.id_imm, 32'hFFFF_FFFF);
        check("st_c_type", id_bus.id_type, 1);

        // ---------------- redirect during stall ----------------
        w_d = enc_r(T_ADD, 5'd5, 5'd6, 5'd4);
        imem[10'h040] = w_d;
        id_bus.id_ready = 1'b0;
        step();
        check("rd_hold_ir", id_bus.id_ir, w_c);
        br_taken = 1'b1; br_target = 10'h040;
        step();
        br_taken = 1'b0;
        #1;
        check("rd_valid", id_bus.id_valid, 0);
        check("rd_pc",    imem_addr, 10'h041);
        step();
        check("rd_nx_valid", id_bus.id_valid, 1);
        check("rd_nx_ir",    id_bus.id_ir, w_d);
        check("rd_nx_npc",   id_bus.id_npc, 10'h041);
        check("rd_nx_pc",    imem_addr, 10'h042);

        // ---------------- write-back bypass ----------------
        imem[0] = enc_r(T_ADD, 5'd3, 5'd0, 5'd7);
        imem[1] = enc_r(T_ADD, 5'd0, 5'd3, 5'd8);
        id_bus.id_ready = 1'b1;
        do_reset();
        step();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
        step();
`ifdef MIPS_FD_WB_BYPASS_EN
        check("byp_a_r3", id_bus.id_a, 32'hDEAD_BEEF);
`else
        check("byp_a_r3", id_bus.id_a, 32'h0);
`endif
        wb_addr = 5'd0; wb_data = 32'h0000_0055;
        step();
        check("byp_a_r0", id_bus.id_a, 32'h0);
        check("byp_b_r3", id_bus.id_b, 32'hDEAD_BEEF);
        wb_en = 1'b0;

        // ---------------- PC wrap and HLT squash ----------------
        w_e = enc_i(T_ADDI, 5'd0, 5'd1, 16'h0123);
        w_f = enc_i(T_ADDI, 5'd0, 5'd2, 16'h8000);
        imem[10'h3FE] = w_e; imem[10'h3FF] = w_hlt; imem[10'h010] = w_f;
        do_reset();
        step();
        br_taken = 1'b1; br_target = 10'h3FE;
        step();
        br_taken = 1'b0;
        #1;
        check("wr_valid", id_bus.id_valid, 0);
        check("wr_pc3ff", imem_addr, 10'h3FF);
        step();
        check("wr_ir_e",  id_bus.id_ir, w_e);
        check("wr_npc_e", id_bus.id_npc, 10'h3FF);
        check("wr_pc0",   imem_addr, 10'h000);
        step();
        check("wr_ir_h",   id_bus.id_ir, w_hlt);
        check("wr_type_h", id_bus.id_type, 5);
        check("wr_npc_h",  id_bus.id_npc, 10'h000);
        check("wr_pc1",    imem_addr, 10'h001);
        br_taken = 1'b1; br_target = 10'h010;
        step();
        br_taken = 1'b0;
        #1;
        check("sq_halted", id_bus.halted, 0);
        check("sq_valid",  id_bus.id_valid, 0);
        check("sq_pc",     imem_addr, 10'h011);
        step();
        check("sq_nx_valid", id_bus.id_valid, 1);
        check("sq_nx_ir",    id_bus.id_ir, w_f);
        check("sq_nx_npc",   id_bus.id_npc, 10'h011);
        check("sq_nx_imm",   id_bus.id_imm, 32'hFFFF_8000);
        step();
        check("sq_halted2", id_bus.halted, 0);
        check("sq_pc2",     imem_addr, 10'h013);

        // ---------------- reset mid-run ----------------
        imem[0] = enc_r(T_ADD, 5'd1, 5'd31, 5'd9);
        imem[1] = w_hlt;
        id_bus.id_ready = 1'b0;
        do_reset();
        for (int i = 1; i < 32; i++) begin
            wb_en = 1'b1; wb_addr = 5'(i); wb_data = 32'h1000_0000 + i;
            step();
        end
        wb_en = 1'b0;
        br_taken = 1'b1; br_target = 10'h000;
        step();
        br_taken = 1'b0;
        id_bus.id_ready = 1'b1;
        step();
        check("mr_pre_valid", id_bus.id_valid, 1);
        check("mr_pre_a",     id_bus.id_a, 32'h1000_0001);
        check("mr_pre_b",     id_bus.id_b, 32'h1000_001F);
        step();
        check("mr_hlt_type",  id_bus.id_type, 5);
        check("mr_hlt_valid", id_bus.id_valid, 1);
        id_bus.id_ready = 1'b0;
        rst = 1'b1;
        step();
        check("mr_valid",  id_bus.id_valid, 0);
        check("mr_halted", id_bus.halted, 0);
        check("mr_ir",     id_bus.id_ir, 0);
        check("mr_npc",    id_bus.id_npc, 0);
        check("mr_a",      id_bus.id_a, 0);
        check("mr_b",      id_bus.id_b, 0);
        check("mr_imm",    id_bus.id_imm, 0);
        check("mr_type",   id_bus.id_type, 0);
        check("mr_pc",     imem_addr, 0);
        step();
        for (int k = 0; k < 16; k++) begin
            rs_k = 5'(2 * k + 1);
            rt_k = (k == 15) ? 5'd31 : 5'(2 * k + 2);
            imem[k] = enc_r(T_ADD, rs_k, rt_k, 5'd0);
        end
        rst = 1'b0;
        id_bus.id_ready = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            step();
            check($sformatf("mr_rd_valid%0d", k), id_bus.id_valid, 1);
            check($sformatf("mr_rd_a%0d", k),     id_bus.id_a, 0);
            check($sformatf("mr_rd_b%0d", k),     id_bus.id_b, 0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_fetch_decode.md
MIPS_FETCH_DECODE -- requirements
Module: mips_fetch_decode

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and instruction width.
REQ-002 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width; PC counts in words.
REQ-003 SHALL have parameter NREG, default 32, register count; REG_AW = clog2(NREG).
REQ-004 SHALL have port clk1 input 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst input 1, synchronous active-high reset.
REQ-006 SHALL have port imem_addr output ADDR_W, equal to the PC; imem_rdata input XLEN, combinational read data.
REQ-007 SHALL have ports br_taken input 1 and br_target input ADDR_W, the branch redirect from the EX/MEM stage.
REQ-008 SHALL have ports wb_en input 1, wb_addr input REG_AW and wb_data input XLEN, the write-back port.
REQ-009 SHALL have ports id_valid output 1 and id_ready input 1, the ID/EX handshake.
REQ-010 SHALL have outputs id_ir XLEN, id_npc ADDR_W, id_a XLEN, id_b XLEN, id_imm XLEN and id_type 3, the ID/EX latch.
REQ-011 SHALL have port halted output 1, high once HLT has been handed to EX.

Function
REQ-012 SHALL be two stages: F (PC to IF/ID latch if_valid/if_ir/if_npc) and D (IF/ID to ID/EX latch).
REQ-013 SHALL define adv = !id_valid || id_ready; when adv=1 both latches load and the PC increments by 1; when adv=0 the PC and both latches hold.
REQ-014 SHALL wrap the PC modulo 2^ADDR_W (PC = 2^ADDR_W-1 increments to 0); npc = PC+1 with the same wrap.
REQ-015 SHALL load PC <= br_target+1, if_ir <= imem word at br_target, if_valid <= 1 and id_valid <= 0 when br_taken=1, regardless of id_ready; br_taken overrides stall.
REQ-016 SHALL read rs = ir[25:21] and rt = ir[20:16] into id_a and id_b; register 0 SHALL read 0.
REQ-017 SHALL sign-extend ir[15:0] to XLEN into id_imm.
REQ-018 SHALL decode id_type from ir[31:26] as follows:
- ADD, SUB, AND, OR, SLT, MUL -> RR_ALU
- ADDI, SUBI, SLTI -> RM_ALU
- LW -> LOAD
- SW -> STORE
- BEQZ, BNEQZ -> BRANCH
- HLT and any undefined opcode -> HALT
REQ-019 SHALL write wb_data to register wb_addr at the edge when wb_en=1 and wb_addr!=0; writes to register 0 are ignored.
REQ-020 SHALL set halt_pending when a HALT-type instruction loads into ID/EX; while it is set, if_valid loads 0 and the PC holds.
REQ-021 SHALL clear halt_pending when br_taken=1, which squashes the pending HLT.
REQ-022 SHALL set halted one cycle after a HALT-type instruction is accepted (id_valid && id_ready); halted is then sticky until rst, and all fetch/decode state freezes.
REQ-023 SHALL continue to accept write-back writes while halted.

Reset
REQ-024 SHALL, when rst=1 at an edge, clear the following to 0:
- PC, if_valid, id_valid, halt_pending, halted
- all ID/EX outputs and every register
REQ-025 SHALL give rst priority over br_taken, wb_en and the handshake.
REQ-026 SHALL make the first fetch after reset release (PC=0) appear as id_valid=1 two edges later.

Configuration
REQ-027 SHALL use macro MIPS_FD_WB_BYPASS_EN. When it is defined, a D-stage read of register r with wb_en=1, wb_addr=r and r!=0 in the same cycle SHALL return wb_data. When it is undefined, that read SHALL return the pre-write value.

Structure
REQ-028 SHALL take from shared package mips_pkg:
- opcode constants: ADD..BEQZ, HLT
- instruction-type enum: RR_ALU=0, RM_ALU=1, LOAD=2, STORE=3, BRANCH=4, HALT=5
REQ-029 SHALL instantiate one sub-module, mips_regfile: NREG x XLEN, 2 combinational read ports, 1 synchronous write port, reset clear, and the optional bypass.

Verification
REQ-030 Straight-line: imem[0..2] = ADDI r1,r0,5; ADD r2,r1,r1; HLT, with id_ready=1 -> id_valid on edges 2, 3 and 4 with id_imm=5, id_type RM_ALU then RR_ALU; halted=1 one edge after HLT is accepted; the PC then frozen.
REQ-031 Stall: hold id_ready=0 for 3 cycles with id_valid=1 -> id_ir, id_npc and the PC are unchanged; the next instruction appears on the first edge after id_ready=1.
REQ-032 Redirect during stall: id_ready=0, then br_taken=1 with br_target=0x040 -> id_valid=0 next edge, PC=0x041, if_ir=imem[0x040].
REQ-033 Bypass: wb_en=1, wb_addr=3, wb_data=0xDEADBEEF while D reads rs=3 (old r3=0):
- with MIPS_FD_WB_BYPASS_EN defined -> id_a=0xDEADBEEF
- without it -> id_a=0
- wb_addr=0 -> id_a=0 in both builds
REQ-034 Wrap and squash:
- PC=0x3FF -> next PC=0x000 and id_npc=0x000 for that instruction
- HLT in ID/EX with br_taken=1 -> halted stays 0 and fetch resumes at br_target+1
REQ-035 Reset mid-run: assert rst with id_valid=1 and halt_pending=1 -> all outputs 0 next edge; r1..r31 read 0.
